// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage data-memory access controller. A load/store presented by the
//   EX/MEM register is turned into a single request/acknowledge handshake with
//   the data memory while the pipeline is frozen. A request that sees no
//   acknowledge within TIMEOUT wait cycles is aborted with a bus-error strobe.
//
// Parameters
//   TIMEOUT    : maximum WAIT cycles without memAck before abort (1..255)
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-high reset
//   memReadIn  : EX/MEM load control
//   memWriteIn : EX/MEM store control (wins over memReadIn)
//   addrIn     : EX/MEM ALU result, used as the access address
//   wdataIn    : EX/MEM store data
//   memAck     : one-cycle completion strobe from data memory
//   memRdata   : data-memory read data, valid with memAck
//   memReq     : registered access request
//   memWe      : registered write enable qualifying memReq
//   memAddr    : latched access address
//   memWdata   : latched store data
//   stall      : combinational freeze request to PC and pipeline registers
//   rdataOut   : read data towards MEM/WB
//   rdataValid : one-cycle strobe, rdataOut carries a completed load
//   busErr     : one-cycle strobe, the access timed out
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [31:0] addrIn,
  input  logic [31:0] wdataIn,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic        stall,
  output logic [31:0] rdataOut,
  output logic        rdataValid,
  output logic        busErr
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_s;
  logic [7:0]  cnt_inc_s;
  logic        req_s;
  logic        we_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  logic        valid_s;
  logic        err_s;
  logic        stall_s;

  assign cnt_inc_s = cnt_r + 8'd1;

  // Reset forces the freeze request low even if a request is presented.
  assign stall = stall_s & ~rst;

  // Next-state and next-register computation for the access FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    req_s   = memReq;
    we_s    = memWe;
    addr_s  = memAddr;
    wdata_s = memWdata;
    rdata_s = rdataOut;
    valid_s = 1'b0;
    err_s   = 1'b0;
    stall_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (memReadIn || memWriteIn) begin
          stall_s = 1'b1;
          state_s = WAIT;
          req_s   = 1'b1;
          // A combined read+write request is executed as a write.
          we_s    = memWriteIn;
          addr_s  = addrIn;
          wdata_s = wdataIn;
          cnt_s   = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end

      WAIT: begin
        stall_s = 1'b1;
        // Acknowledge has priority over a timeout landing in the same cycle.
        if (memAck) begin
          state_s = DONE;
          req_s   = 1'b0;
          we_s    = 1'b0;
          // memWe low in WAIT means the access is a load.
          if (!memWe) begin
            rdata_s = memRdata;
            valid_s = 1'b1;
          end else begin
            rdata_s = rdataOut;
          end
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_s = ERR;
          cnt_s   = cnt_inc_s;
          req_s   = 1'b0;
          we_s    = 1'b0;
          rdata_s = 32'h0000_0000;
          err_s   = 1'b1;
        end else begin
          cnt_s   = cnt_inc_s;
        end
      end

      // Request inputs are ignored here so the just-released instruction
      // does not start a second access.
      DONE: begin
        state_s = IDLE;
      end

      ERR: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter and registered output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= 32'h0000_0000;
      memWdata   <= 32'h0000_0000;
      rdataOut   <= 32'h0000_0000;
      rdataValid <= 1'b0;
      busErr     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      memReq     <= req_s;
      memWe      <= we_s;
      memAddr    <= addr_s;
      memWdata   <= wdata_s;
      rdataOut   <= rdata_s;
      rdataValid <= valid_s;
      busErr     <= err_s;
    end
  end

endmodule
